note_play_scheduler: RTL

//  Sequences the piano tone datapath from decoded PS/2 key codes. Fetches the note's half-period from the

---
 rtl/note_play_scheduler.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/note_play_scheduler.sv
// note_play_scheduler
// Turns decoded PS/2 key codes into a click-free square-wave tone. It fetches the
// note half-period from an external note ROM, runs the tone counter, and only
// switches or stops a note at the end of a full period.
// Optional feature: define AUTO_RELEASE_EN to release a note after MAX_PERIODS
// full periods. Without it a note sounds until a stop code or another note.

module note_play_scheduler #(
    parameter int unsigned NOTE_MAX    = 21,
    parameter int unsigned STOP_CODE   = 99,
    parameter int unsigned HP_W        = 13,
    parameter int unsigned ROM_LAT     = 1,
    parameter int unsigned MAX_PERIODS = 255
) (
    input  logic            iClk,
    input  logic            iReset,
    input  logic            iKeyValid,
    input  logic [7:0]      iPs2_Data,
    output logic [7:0]      oNoteAddr,
    input  logic [HP_W-1:0] iHalfPeriod,
    output logic            oRing,
    output logic            oCountEnable,
    output logic [7:0]      oNote
);

    localparam int unsigned FETCH_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PLAY,
        ST_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        note_addr_q, note_addr_d;
    logic [7:0]        note_q, note_d;
    logic              ring_q, ring_d;
    logic              count_en_q, count_en_d;
    logic [HP_W-1:0]   hp_q, hp_d;
    logic [HP_W-1:0]   cnt_q, cnt_d;
    logic [FETCH_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic              pend_valid_q, pend_valid_d;
    logic [7:0]        pend_code_q, pend_code_d;
`ifdef AUTO_RELEASE_EN
    logic [7:0]        periods_q, periods_d;
`endif

    logic       key_note;
    logic       key_stop;
    logic       half_last;
    logic       period_end;
    logic       fetch_done;
    logic       take_note;
    logic       accept_note;
    logic       go_fetch;
    logic       go_idle;
    logic [7:0] fetch_code;

    // Decode the key strobe and the tone counter boundaries
    always_comb begin
        key_note   = iKeyValid && (iPs2_Data != 8'd0) && (iPs2_Data <= 8'(NOTE_MAX));
        key_stop   = iKeyValid && (iPs2_Data == 8'(STOP_CODE));
        half_last  = (cnt_q == (hp_q - HP_W'(1)));
        period_end = !ring_q && half_last;
        fetch_done = (fetch_cnt_q == FETCH_W'(ROM_LAT - 1));
        take_note  = key_note && ((iPs2_Data != note_q) || pend_valid_q);
    end

    // Next-state logic: sequencing, tone generation and pending-note handling
    always_comb begin
        state_d      = state_q;
        note_addr_d  = note_addr_q;
        note_d       = note_q;
        ring_d       = ring_q;
        count_en_d   = count_en_q;
        hp_d         = hp_q;
        cnt_d        = cnt_q;
        fetch_cnt_d  = fetch_cnt_q;
        pend_valid_d = pend_valid_q;
        pend_code_d  = pend_code_q;
`ifdef AUTO_RELEASE_EN
        periods_d    = periods_q;
`endif
        go_fetch     = 1'b0;
        go_idle      = 1'b0;
        fetch_code   = pend_code_q;
        accept_note  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_note) begin
                    go_fetch   = 1'b1;
                    fetch_code = iPs2_Data;
                end
            end

            ST_FETCH: begin
                if (key_stop) begin
                    state_d = ST_IDLE;
                end else if (key_note) begin
                    go_fetch   = 1'b1;
                    fetch_code = iPs2_Data;
                end else if (fetch_done) begin
                    if (iHalfPeriod < HP_W'(2)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d      = ST_PLAY;
                        hp_d         = iHalfPeriod;
                        cnt_d        = '0;
                        ring_d       = 1'b1;
                        count_en_d   = 1'b1;
                        note_d       = note_addr_q;
                        pend_valid_d = 1'b0;
`ifdef AUTO_RELEASE_EN
                        periods_d    = '0;
`endif
                    end
                end else begin
                    fetch_cnt_d = fetch_cnt_q + FETCH_W'(1);
                end
            end

            ST_PLAY, ST_DRAIN: begin
                if (half_last) begin
                    cnt_d  = '0;
                    ring_d = !ring_q;
                end else begin
                    cnt_d = cnt_q + HP_W'(1);
                end

                accept_note = (state_q == ST_DRAIN) ? key_note : take_note;

                if (key_stop) begin
                    pend_valid_d = 1'b0;
                    state_d      = ST_DRAIN;
                end else if (accept_note) begin
                    pend_valid_d = 1'b1;
                    pend_code_d  = iPs2_Data;
                end

                if (period_end) begin
                    if (key_stop) begin
                        go_idle = 1'b1;
                    end else if (accept_note) begin
                        go_fetch   = 1'b1;
                        fetch_code = iPs2_Data;
                    end else if (pend_valid_q) begin
                        go_fetch = 1'b1;
                    end else if (state_q == ST_DRAIN) begin
                        go_idle = 1'b1;
`ifdef AUTO_RELEASE_EN
                    end else if (({1'b0, periods_q} + 9'd1) >= 9'(MAX_PERIODS)) begin
                        go_idle = 1'b1;
`endif
                    end
                end

`ifdef AUTO_RELEASE_EN
                if (period_end && !go_idle && !go_fetch && (periods_q != 8'hFF)) begin
                    periods_d = periods_q + 8'd1;
                end
                if ((state_q == ST_PLAY) && key_note && (iPs2_Data == note_q) && !pend_valid_q) begin
                    periods_d = '0;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_fetch) begin
            state_d      = ST_FETCH;
            note_addr_d  = fetch_code;
            fetch_cnt_d  = '0;
            ring_d       = 1'b0;
            count_en_d   = 1'b0;
            note_d       = 8'd0;
            cnt_d        = '0;
            pend_valid_d = 1'b0;
        end

        if (go_idle) begin
            state_d      = ST_IDLE;
            ring_d       = 1'b0;
            count_en_d   = 1'b0;
            note_d       = 8'd0;
            cnt_d        = '0;
            pend_valid_d = 1'b0;
        end
    end

    // State and datapath registers; reset silences immediately
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q      <= ST_IDLE;
            note_addr_q  <= 8'd0;
            note_q       <= 8'd0;
            ring_q       <= 1'b0;
            count_en_q   <= 1'b0;
            hp_q         <= '0;
            cnt_q        <= '0;
            fetch_cnt_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_code_q  <= 8'd0;
`ifdef AUTO_RELEASE_EN
            periods_q    <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            note_addr_q  <= note_addr_d;
            note_q       <= note_d;
            ring_q       <= ring_d;
            count_en_q   <= count_en_d;
            hp_q         <= hp_d;
            cnt_q        <= cnt_d;
            fetch_cnt_q  <= fetch_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_code_q  <= pend_code_d;
`ifdef AUTO_RELEASE_EN
            periods_q    <= periods_d;
`endif
        end
    end

    assign oNoteAddr    = note_addr_q;
    assign oRing        = ring_q;
    assign oCountEnable = count_en_q;
    assign oNote        = note_q;

endmodule
